// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and sizing helpers shared by seq_alu and seq_mul
package alu_pkg;
  typedef enum logic [2:0] {
    OP_NEG_A   = 3'b000,
    OP_NEG_B   = 3'b001,
    OP_ADD     = 3'b010,
    OP_ABSDIFF = 3'b011,
    OP_AND     = 3'b100,
    OP_OR      = 3'b101,
    OP_MUL_LO  = 3'b110,
    OP_MUL_HI  = 3'b111
  } op_e;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_e;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W = $clog2(DEF_WIDTH);

  // step counter width for a given operand width
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/seq_mul.sv
// seq_mul: WIDTH-step unsigned shift-add multiplier with a one-cycle done strobe
module seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = cnt_w(WIDTH);

  logic             busy_q, busy_d, last;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0]   sum;

  // product is the value after the current step, so done and product line up on the last step
  always_comb begin
    sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, p_q[0] ? m_q : {WIDTH{1'b0}}};
    last = cnt_q == CW'(WIDTH - 1);
    done = busy_q && last;
    product = {sum, p_q[WIDTH-1:1]};
    busy_d = busy_q;
    cnt_d = cnt_q;
    m_d = m_q;
    p_d = p_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d = '0;
      m_d = a;
      p_d = {{WIDTH{1'b0}}, b};
    end else if (busy_q) begin
      busy_d = !last;
      cnt_d = cnt_q + 1'b1;
      p_d = product;
    end
  end

  // multiplier state; reset discards any partial product
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      cnt_q <= '0;
      m_q <= '0;
      p_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      m_q <= m_d;
      p_q <= p_d;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered flags and a sequential multiplier
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);
  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d, alu_res;
  logic               carry_q, carry_d, zero_q, zero_d, alu_c, accept, mul_done;
  logic [WIDTH:0]     add_s;
  logic [2*WIDTH-1:0] product;

  assign in_ready = resetn && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign carry = carry_q;
  assign zero = zero_q;

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .resetn(resetn),
    .start(accept && op[2:1] == 2'b11),
    .a(a),
    .b(b),
    .done(mul_done),
    .product(product)
  );

  // result and flag for the latched op; multiply ops read the multiplier output
  always_comb begin
    add_s = {1'b0, a_q} + {1'b0, b_q};
    alu_res = '0;
    alu_c = 1'b0;
    case (op_q)
      OP_NEG_A:   alu_res = -a_q;
      OP_NEG_B:   alu_res = -b_q;
      OP_ADD:     {alu_c, alu_res} = add_s;
      OP_ABSDIFF: begin
        alu_c = a_q < b_q;
        alu_res = alu_c ? b_q - a_q : a_q - b_q;
      end
      OP_AND:     alu_res = a_q & b_q;
      OP_OR:      alu_res = a_q | b_q;
      OP_MUL_LO:  begin
        alu_res = product[WIDTH-1:0];
        alu_c = |product[2*WIDTH-1:WIDTH];
      end
      OP_MUL_HI:  alu_res = product[2*WIDTH-1:WIDTH];
      default:    alu_res = '0;
    endcase
  end

  // handshake FSM: accept in IDLE or at the DONE hand-off, capture outputs on completion
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    result_d = result_q;
    carry_d = carry_q;
    zero_d = zero_q;
    if (accept) begin
      a_d = a;
      b_d = b;
      op_d = op_e'(op);
      state_d = op[2:1] == 2'b11 ? MUL : EXEC;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end else if (state_q == EXEC || (state_q == MUL && mul_done)) begin
      result_d = alu_res;
      carry_d = alu_c;
      zero_d = alu_res == '0;
      state_d = DONE;
    end
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q <= OP_NEG_A;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      result_q <= result_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random scoreboard bench for seq_alu at WIDTH=8
module tb_seq_alu;
  logic       clk = 1'b0;
  logic       resetn, in_valid, in_ready, out_valid, out_ready, carry, zero;
  logic [7:0] a, b, result;
  logic [2:0] op;
  int         checks = 0, failures = 0, handoffs = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_m;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero)
  );

  function automatic logic [9:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int xi, yi, r, c, p;
    xi = int'(x);
    yi = int'(y);
    p = xi * yi;
    c = 0;
    case (o)
      3'd0: r = (256 - xi) % 256;
      3'd1: r = (256 - yi) % 256;
      3'd2: begin r = (xi + yi) % 256; c = (xi + yi > 255) ? 1 : 0; end
      3'd3: begin r = xi < yi ? yi - xi : xi - yi; c = xi < yi ? 1 : 0; end
      3'd4: r = xi & yi;
      3'd5: r = xi | yi;
      3'd6: begin r = p % 256; c = p > 255 ? 1 : 0; end
      default: r = p / 256;
    endcase
    return {r[7:0], c[0], r == 0};
  endfunction

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      handoffs++;
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_underflow got=%h exp=none", {result, carry, zero});
      end
      if (sb.size() > 0) begin
        exp_m = sb.pop_front();
        checks++;
        assert ({result, carry, zero} === exp_m) else begin
          failures++;
          $error("FAIL sb_result got=%h exp=%h", {result, carry, zero}, exp_m);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, output logic hv);
    int n;
    n = 0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    hv = out_valid;
    if (n >= 100) chk("accept_timeout", n, 0);
    else begin
      tick();
      sb.push_back(model(o, x, y));
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 50);
  endtask

  initial begin
    int   lat, h0, n, bad;
    logic hv, any;
    resetn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    op = '0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 0);
    resetn = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    send(3'd2, 8'hF0, 8'h20, hv);
    wait_valid(lat);
    chk("add_lat", lat, 1);
    chk("add_res", {result, carry, zero}, {8'h10, 1'b1, 1'b0});
    tick();
    chk("add_handoff", out_valid, 0);

    send(3'd3, 8'h05, 8'h09, hv);
    wait_valid(lat);
    chk("absdiff_lat", lat, 1);
    chk("absdiff_res", {result, carry, zero}, {8'h04, 1'b1, 1'b0});
    tick();

    send(3'd0, 8'h00, 8'h5A, hv);
    wait_valid(lat);
    chk("neg_a_res", {result, carry, zero}, {8'h00, 1'b0, 1'b1});
    tick();

    send(3'd6, 8'h10, 8'h20, hv);
    wait_valid(lat);
    chk("mul_lo_lat", lat, 8);
    chk("mul_lo_res", {result, carry, zero}, {8'h00, 1'b1, 1'b1});
    tick();

    send(3'd7, 8'h10, 8'h20, hv);
    wait_valid(lat);
    chk("mul_hi_lat", lat, 8);
    chk("mul_hi_res", {result, carry, zero}, {8'h02, 1'b0, 1'b0});
    tick();

    send(3'd6, 8'hFF, 8'hFF, hv);
    repeat (4) tick();
    resetn = 1'b0;
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_carry", carry, 0);
    chk("midrst_zero", zero, 0);
    chk("midrst_in_ready_low", in_ready, 0);
    sb.delete();
    resetn = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    any = 1'b0;
    repeat (10) begin
      tick();
      any = any | out_valid;
    end
    chk("midrst_no_stray", any, 0);

    out_ready = 1'b0;
    send(3'd4, 8'hAA, 8'h0F, hv);
    wait_valid(lat);
    chk("bp_lat", lat, 1);
    h0 = handoffs;
    any = 1'b1;
    repeat (5) begin
      any = any & (result == 8'h0A) & !carry & !zero & out_valid & !in_ready;
      tick();
    end
    chk("bp_stable", any, 1);
    chk("bp_no_handoff", handoffs, h0);
    out_ready = 1'b1;
    tick();
    chk("bp_handoff_once", handoffs, h0 + 1);
    chk("bp_idle", out_valid, 0);

    h0 = handoffs;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) send(3'd5, 8'h3C, 8'hC3, hv);
      else if (i == 1) send(3'd2, 8'h7F, 8'h81, hv);
      else if (i == 2) send(3'd7, 8'hFF, 8'hFE, hv);
      else send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), hv);
      if (i > 0 && !hv) bad++;
    end
    chk("b2b_overlap", bad, 0);
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    chk("b2b_handoffs", handoffs, h0 + 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
